// File: rtl/bist_pkg.sv
// Shared definitions for the BIST MISR checker: FSM state encoding,
// MISR tap masks per width and the value substituted for an all-zero seed.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_COMPACT = 3'd2,
        ST_COMPARE = 3'd3,
        ST_RESULT  = 3'd4
    } bist_state_t;

    // Feedback taps: bits 15,13,12,10 for 16-bit, bits 7,5,4,3 for 8-bit.
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;

    // An all-zero MISR never leaves zero on zero input, so seed 0 becomes 1.
    localparam logic [63:0] ZERO_SEED_SUB = 64'd1;

endpackage

// File: rtl/bist_misr_checker_if.sv
// Bundles the BIST control, response and result signals of the checker.
// master: stimulus side (drives run/response/seed/golden); slave: checker.
interface bist_misr_checker_if #(
    parameter int RESP_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
);
    logic                   bist_active;
    logic                   bist_done;
    logic                   resp_valid;
    logic [RESP_WIDTH-1:0]  resp_data;
    logic [RESP_WIDTH-1:0]  misr_seed;
    logic [RESP_WIDTH-1:0]  golden_sig;
    logic [RESP_WIDTH-1:0]  signature;
    logic [COUNT_WIDTH-1:0] resp_count;
    logic                   sig_valid;
    logic                   bist_pass;
    logic                   bist_fail;
    logic                   bist_abort;
    logic                   stray_resp;
    logic                   busy;

    modport master (
        output bist_active, bist_done, resp_valid, resp_data,
        output misr_seed, golden_sig,
        input  signature, resp_count, sig_valid, bist_pass,
        input  bist_fail, bist_abort, stray_resp, busy
    );

    modport slave (
        input  bist_active, bist_done, resp_valid, resp_data,
        input  misr_seed, golden_sig,
        output signature, resp_count, sig_valid, bist_pass,
        output bist_fail, bist_abort, stray_resp, busy
    );
endinterface

// File: rtl/misr_core.sv
// Multiple-input signature register with seed load and compaction step.
// Ports: clk_in, rst_n, seed_load/seed, compact_en/resp_data, misr (state).
module misr_core
    import bist_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    input  logic         compact_en,
    input  logic [W-1:0] resp_data,
    output logic [W-1:0] misr
);

    localparam logic [W-1:0] TAPS_GEN = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [W-1:0] TAPS =
        (W == 16) ? W'(TAPS_W16) :
        (W == 8)  ? W'(TAPS_W8)  : TAPS_GEN;
    localparam logic [W-1:0] SUB = W'(ZERO_SEED_SUB);

    logic fb;

    assign fb = ^(misr & TAPS);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            misr <= SUB;
        end else if (seed_load) begin
            misr <= (seed == '0) ? SUB : seed;
        end else if (compact_en) begin
            misr <= {misr[W-2:0], fb} ^ resp_data;
        end
    end

endmodule

// File: rtl/bist_misr_checker.sv
// BIST response checker: seeds a MISR, compacts responses, compares result.
// Ports: clk_in, rst_n, bus (slave side of bist_misr_checker_if).
module bist_misr_checker #(
    parameter int RESP_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    bist_misr_checker_if.slave   bus
);
    import bist_pkg::*;

    bist_state_t            state_q;
    bist_state_t            state_d;
    logic                   act_q;
    logic                   rise;
    logic                   seed_load;
    logic                   compact_en;
    logic                   match;
    logic [RESP_WIDTH-1:0]  misr;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   sig_valid_q;
    logic                   pass_q;
    logic                   fail_q;
    logic                   abort_q;
    logic                   stray_q;
    logic                   busy_q;

    assign rise  = bus.bist_active & ~act_q;
    assign match = (misr == bus.golden_sig);

    misr_core #(.W(RESP_WIDTH)) u_misr (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .seed_load  (seed_load),
        .seed       (bus.misr_seed),
        .compact_en (compact_en),
        .resp_data  (bus.resp_data),
        .misr       (misr)
    );

    always_comb begin
        state_d    = state_q;
        seed_load  = 1'b0;
        compact_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_SEED;
            end
            ST_SEED: begin
                seed_load = 1'b1;
                state_d   = ST_COMPACT;
            end
            ST_COMPACT: begin
                // An aborting cycle leaves the MISR frozen.
                compact_en = bus.resp_valid &
                             (bus.bist_done | bus.bist_active);
                if (bus.bist_done) begin
                    state_d = ST_COMPARE;
                end else if (!bus.bist_active) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (rise) begin
                    state_d = ST_SEED;
                end else if (!bus.bist_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            act_q       <= 1'b0;
            count_q     <= '0;
            sig_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            abort_q     <= 1'b0;
            stray_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= bus.bist_active;
            busy_q  <= (state_d == ST_SEED) ||
                       (state_d == ST_COMPACT) ||
                       (state_d == ST_COMPARE);
            unique case (state_q)
                ST_SEED: begin
                    count_q     <= '0;
                    sig_valid_q <= 1'b0;
                    pass_q      <= 1'b0;
                    fail_q      <= 1'b0;
                    abort_q     <= 1'b0;
                    // A response during seeding is itself stray.
                    stray_q     <= bus.resp_valid;
                end
                ST_COMPACT: begin
                    if (compact_en && (count_q != '1)) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (state_d == ST_IDLE) abort_q <= 1'b1;
                end
                ST_COMPARE: begin
                    sig_valid_q <= 1'b1;
                    pass_q      <= match;
                    fail_q      <= ~match;
                    stray_q     <= stray_q | bus.resp_valid;
                end
                default: begin
                    stray_q <= stray_q | bus.resp_valid;
                end
            endcase
        end
    end

    assign bus.signature  = misr;
    assign bus.resp_count = count_q;
    assign bus.sig_valid  = sig_valid_q;
    assign bus.bist_pass  = pass_q;
    assign bus.bist_fail  = fail_q;
    assign bus.bist_abort = abort_q;
    assign bus.stray_resp = stray_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Self-checking bench for bist_misr_checker (W=16): directed scenarios,
// then randomized traffic, all compared each cycle to a behavioural model.
module tb_bist_misr_checker;

    localparam int M_IDLE    = 0;
    localparam int M_SEED    = 1;
    localparam int M_COMPACT = 2;
    localparam int M_COMPARE = 3;
    localparam int M_RESULT  = 4;

    typedef struct {
        int         mode;
        logic       prev_act;
        logic [15:0] misr;
        logic [7:0] cnt;
        logic       sv;
        logic       pass;
        logic       fail;
        logic       abort;
        logic       stray;
        logic       busy;
    } model_t;

    logic   clk_in = 1'b0;
    logic   rst_n  = 1'b0;
    logic   chk_en = 1'b0;
    int     errors = 0;
    int     checks = 0;
    model_t m;

    bist_misr_checker_if #(.RESP_WIDTH(16), .COUNT_WIDTH(8)) bus ();

    bist_misr_checker #(.RESP_WIDTH(16), .COUNT_WIDTH(8)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Signature step from the polynomial: shift left, feed back taps, xor in.
    function automatic logic [15:0] misr_step(logic [15:0] s, logic [15:0] r);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return ((s << 1) | {15'd0, fb}) ^ r;
    endfunction

    function automatic model_t model_next(model_t c, logic rst, logic act,
                                          logic done, logic rv,
                                          logic [15:0] rd, logic [15:0] seed,
                                          logic [15:0] gold);
        model_t n;
        logic   rise;
        n = c;
        if (!rst) begin
            n = '{mode: M_IDLE, prev_act: 1'b0, misr: 16'd1, cnt: 8'd0,
                  sv: 1'b0, pass: 1'b0, fail: 1'b0, abort: 1'b0,
                  stray: 1'b0, busy: 1'b0};
            return n;
        end
        rise       = act && !c.prev_act;
        n.prev_act = act;
        case (c.mode)
            M_IDLE: begin
                if (rv) n.stray = 1'b1;
                if (rise) n.mode = M_SEED;
            end
            M_SEED: begin
                n.misr  = (seed == 16'd0) ? 16'd1 : seed;
                n.cnt   = 8'd0;
                n.sv    = 1'b0;
                n.pass  = 1'b0;
                n.fail  = 1'b0;
                n.abort = 1'b0;
                n.stray = rv;
                n.mode  = M_COMPACT;
            end
            M_COMPACT: begin
                if (!done && !act) begin
                    n.abort = 1'b1;
                    n.mode  = M_IDLE;
                end else begin
                    if (rv) begin
                        n.misr = misr_step(c.misr, rd);
                        if (c.cnt != 8'd255) n.cnt = c.cnt + 8'd1;
                    end
                    if (done) n.mode = M_COMPARE;
                end
            end
            M_COMPARE: begin
                n.sv    = 1'b1;
                n.pass  = (c.misr == gold);
                n.fail  = (c.misr != gold);
                n.stray = c.stray | rv;
                n.mode  = M_RESULT;
            end
            default: begin
                n.stray = c.stray | rv;
                if (rise) n.mode = M_SEED;
                else if (!done) n.mode = M_IDLE;
            end
        endcase
        n.busy = (n.mode == M_SEED) || (n.mode == M_COMPACT) ||
                 (n.mode == M_COMPARE);
        return n;
    endfunction

    always @(posedge clk_in) begin
        m <= model_next(m, rst_n, bus.bist_active, bus.bist_done,
                        bus.resp_valid, bus.resp_data, bus.misr_seed,
                        bus.golden_sig);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("signature",  32'(bus.signature),  32'(m.misr));
            chk("resp_count", 32'(bus.resp_count), 32'(m.cnt));
            chk("sig_valid",  32'(bus.sig_valid),  32'(m.sv));
            chk("bist_pass",  32'(bus.bist_pass),  32'(m.pass));
            chk("bist_fail",  32'(bus.bist_fail),  32'(m.fail));
            chk("bist_abort", 32'(bus.bist_abort), 32'(m.abort));
            chk("stray_resp", 32'(bus.stray_resp), 32'(m.stray));
            chk("busy",       32'(bus.busy),       32'(m.busy));
            chk("pass_xor_fail",
                32'(bus.bist_pass & bus.bist_fail), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    // Rising bist_active: SEED on the first edge, COMPACT after the second.
    task automatic start_run(logic [15:0] seed, logic [15:0] gold);
        bus.misr_seed   = seed;
        bus.golden_sig  = gold;
        bus.bist_active = 1'b1;
        tick();
        tick();
    endtask

    task automatic send(logic [15:0] r);
        bus.resp_valid = 1'b1;
        bus.resp_data  = r;
        tick();
        bus.resp_valid = 1'b0;
    endtask

    // bist_done sampled at edge N; results checked after edge N+2.
    task automatic finish_run();
        bus.bist_done = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic close_run();
        bus.bist_done   = 1'b0;
        bus.bist_active = 1'b0;
        tick();
    endtask

    logic [15:0] exp_sig;

    initial begin
        bus.bist_active = 1'b0;
        bus.bist_done   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_data   = '0;
        bus.misr_seed   = '0;
        bus.golden_sig  = '0;
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;

        chk("rst_signature", 32'(bus.signature), 32'h0001);
        chk("rst_count",     32'(bus.resp_count), 32'd0);
        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("model_step_fb", 32'(misr_step(16'h8000, 16'h0000)), 32'h0001);
        chk("model_step_sh", 32'(misr_step(16'h0001, 16'h0000)), 32'h0002);

        // Pass
        start_run(16'h0001, 16'h0004);
        send(16'h0000);
        send(16'h0000);
        finish_run();
        chk("pass_sig",   32'(bus.signature), 32'h0004);
        chk("pass_count", 32'(bus.resp_count), 32'd2);
        chk("pass_flag",  32'(bus.bist_pass), 32'd1);
        chk("pass_valid", 32'(bus.sig_valid), 32'd1);
        close_run();

        // Fail
        start_run(16'h0001, 16'h0005);
        send(16'h0000);
        send(16'h0000);
        finish_run();
        chk("fail_flag", 32'(bus.bist_fail), 32'd1);
        chk("fail_pass", 32'(bus.bist_pass), 32'd0);
        chk("fail_sv",   32'(bus.sig_valid), 32'd1);
        close_run();

        // Feedback and zero seed
        start_run(16'h8000, 16'h0000);
        chk("seed_load", 32'(bus.signature), 32'h8000);
        send(16'h0000);
        chk("feedback_sig", 32'(bus.signature), 32'h0001);
        finish_run();
        close_run();
        start_run(16'h0000, 16'h0000);
        chk("zero_seed", 32'(bus.signature), 32'h0001);
        finish_run();
        close_run();

        // Abort, with a response in the aborting cycle that must not land
        start_run(16'h1234, 16'h0000);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        exp_sig = misr_step(misr_step(misr_step(16'h1234, 16'h0001),
                                      16'h0002), 16'h0003);
        bus.resp_valid  = 1'b1;
        bus.resp_data   = 16'hFFFF;
        bus.bist_active = 1'b0;
        tick();
        bus.resp_valid = 1'b0;
        chk("abort_flag",  32'(bus.bist_abort), 32'd1);
        chk("abort_sv",    32'(bus.sig_valid), 32'd0);
        chk("abort_count", 32'(bus.resp_count), 32'd3);
        chk("abort_busy",  32'(bus.busy), 32'd0);
        chk("abort_sig",   32'(bus.signature), 32'(exp_sig));

        // Response together with bist_done, then a stray in RESULT
        start_run(16'h0001, 16'h0000);
        send(16'h0000);
        bus.resp_valid = 1'b1;
        bus.resp_data  = 16'h00FF;
        bus.bist_done  = 1'b1;
        tick();
        bus.resp_valid = 1'b0;
        tick();
        tick();
        chk("simul_sig",   32'(bus.signature), 32'h00FB);
        chk("simul_count", 32'(bus.resp_count), 32'd2);
        bus.resp_valid = 1'b1;
        bus.resp_data  = 16'hAAAA;
        tick();
        bus.resp_valid = 1'b0;
        chk("stray_flag", 32'(bus.stray_resp), 32'd1);
        chk("stray_sig",  32'(bus.signature), 32'h00FB);
        close_run();

        // Reset mid-COMPACT, then a clean run
        start_run(16'h5A5A, 16'h0000);
        send(16'h1111);
        send(16'h2222);
        rst_n = 1'b0;
        bus.bist_active = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_sig",   32'(bus.signature), 32'h0001);
        chk("mrst_count", 32'(bus.resp_count), 32'd0);
        chk("mrst_busy",  32'(bus.busy), 32'd0);
        start_run(16'h0001, 16'h0004);
        send(16'h0000);
        send(16'h0000);
        finish_run();
        chk("mrst_pass", 32'(bus.bist_pass), 32'd1);
        close_run();

        // Counter saturation
        start_run(16'hBEEF, 16'h0000);
        for (int i = 0; i < 260; i++) send(16'(i));
        chk("sat_count", 32'(bus.resp_count), 32'd255);
        finish_run();
        close_run();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(199) != 0);
            if ($urandom_range(11) == 0) bus.bist_active = ~bus.bist_active;
            bus.bist_done  = ($urandom_range(9) == 0);
            bus.resp_valid = $urandom_range(1);
            bus.resp_data  = 16'($urandom);
            bus.misr_seed  = ($urandom_range(3) == 0) ? 16'd0 :
                             16'($urandom);
            bus.golden_sig = ($urandom_range(1) == 0) ? m.misr :
                             16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        bus.resp_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_misr_checker.md
BIST_MISR_CHECKER -- requirements
Module: bist_misr_checker

Interface
REQ-001 Parameter RESP_WIDTH, default 16: response/signature width, minimum 4.
REQ-002 Parameter COUNT_WIDTH, default 8: width of the response counter.
REQ-003 Port clk_in  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: synchronous reset, active low.
REQ-005 Port bist_active  input  1: run indication from bist_clock_ctrl.
REQ-006 Port bist_done  input  1: completion indication from bist_clock_ctrl.
REQ-007 Port resp_valid  input  1: response word present this cycle.
REQ-008 Port resp_data  input  RESP_WIDTH: response word from the circuit under test.
REQ-009 Port misr_seed  input  RESP_WIDTH: MISR initial value.
REQ-010 Port golden_sig  input  RESP_WIDTH: expected final signature.
REQ-011 Port signature  output  RESP_WIDTH: current MISR contents.
REQ-012 Port resp_count  output  COUNT_WIDTH: responses compacted this run.
REQ-013 Port sig_valid  output  1: signature final and compared.
REQ-014 Port bist_pass  output  1: final signature equals golden_sig.
REQ-015 Port bist_fail  output  1: final signature differs from golden_sig.
REQ-016 Port bist_abort  output  1: run ended without bist_done (sticky).
REQ-017 Port stray_resp  output  1: resp_valid seen outside compaction (sticky).
REQ-018 Port busy  output  1: high in SEED, COMPACT and COMPARE.

Function
REQ-019 The block SHALL use states IDLE, SEED, COMPACT, COMPARE and RESULT, with all outputs registered.
REQ-020 IDLE -> SEED when bist_active=1 and its registered previous value is 0; RESULT -> SEED under the same rising-edge condition.
REQ-021 SEED SHALL take one cycle and perform the following:
- load the MISR with misr_seed, or with 1 if misr_seed is 0;
- clear resp_count, sig_valid, bist_pass, bist_fail, bist_abort and stray_resp;
- go to COMPACT.
REQ-022 In COMPACT, each cycle with resp_valid=1 SHALL perform the following:
- set MISR <= {MISR[W-2:0], fb} XOR resp_data;
- increment resp_count, saturating at all-ones.
REQ-023 Feedback bit fb:
- RESP_WIDTH=16: MISR[15]^MISR[13]^MISR[12]^MISR[10];
- RESP_WIDTH=8: MISR[7]^MISR[5]^MISR[4]^MISR[3];
- otherwise: MISR[W-1]^MISR[0].
REQ-024 COMPACT -> COMPARE when bist_done=1; a resp_valid in that same cycle SHALL still be compacted.
REQ-025 COMPACT -> IDLE when bist_active=0 and bist_done=0; this transition SHALL set bist_abort, leave sig_valid low and keep the MISR frozen.
REQ-026 COMPARE SHALL take one cycle and perform the following:
- set sig_valid=1;
- set bist_pass=(MISR==golden_sig);
- set bist_fail=~bist_pass;
- go to RESULT.
If bist_done is first sampled at edge N, results are visible after edge N+2.
REQ-027 RESULT -> IDLE when bist_done=0; sig_valid, bist_pass, bist_fail and signature SHALL hold until the next SEED.
REQ-028 resp_valid=1 in IDLE, SEED, COMPARE or RESULT SHALL be ignored for the MISR and SHALL set stray_resp.
REQ-029 bist_pass and bist_fail SHALL never be high simultaneously.
REQ-030 busy SHALL be 1 exactly in SEED, COMPACT and COMPARE.

Reset
REQ-031 On a clk_in edge with rst_n=0, reset SHALL force the following, including mid-run:
- state=IDLE; MISR=1; resp_count=0;
- all flag outputs 0; previous-bist_active register 0.
REQ-032 If bist_active is already 1 at reset release, the block SHALL see a rising edge and enter SEED on the following edge.

Structure
REQ-033 Shared package bist_pkg SHALL hold:
- state encoding constants;
- MISR tap positions per width;
- the zero-seed substitute value.
REQ-034 One sub-module, misr_core, SHALL hold the MISR register with its seed, load and compact controls; the FSM, counter and flags SHALL stay in bist_misr_checker.
REQ-035 Target RTL size is 120-400 lines total.

Verification
REQ-036 The bench SHALL cover these scenarios, with W=16 throughout:
- Pass: seed 0x0001, two responses 0x0000, bist_done, golden 0x0004 -> signature 0x0004, resp_count 2, bist_pass=1 two cycles after bist_done.
- Fail: same stimulus with golden 0x0005 -> bist_fail=1, bist_pass=0, sig_valid=1.
- Feedback and zero seed: seed 0x8000, one response 0x0000 -> signature 0x0001; seed 0x0000 -> MISR loads 0x0001.
- Abort: bist_active drops mid-COMPACT after 3 responses -> bist_abort=1, sig_valid=0, resp_count 3, state IDLE.
- Simultaneous and stray: resp_valid with bist_done in the same cycle -> word compacted; resp_valid while in RESULT -> stray_resp=1, signature unchanged.
- Reset mid-COMPACT: rst_n=0 for one edge -> all outputs at reset values; a new bist_active rise starts a clean run.
